avmm_reg_slave: RTL and testbench

- Avalon-MM 8-bit slave register bank that terminates the soft-CPU system's external avm_m0 master port (8-bit address, 8-bit data, waitrequest, readdatavalid).
- Provides read/write control registers and read-only status registers to the GPSDO fabric.
- Supports programmable write wait states and fixed-latency pipelined reads with back-to-back acceptance.

---
 rtl/avmm_reg_pkg.sv | 49 ++++
 rtl/avmm_rd_pipe.sv | 39 +++
 rtl/avmm_reg_slave.sv | 158 +++++++++++++++
 tb/tb_avmm_reg_slave.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_reg_pkg.sv
// Shared constants, decode types and the address decoder for the Avalon-MM register slave.
// The decoder is a pure function so the read snapshot and the write enable see one answer.
package avmm_reg_pkg;

  localparam int AVM_AW = 8;
  localparam int AVM_DW = 8;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    DEC_RW,
    DEC_RO,
    DEC_NONE
  } dec_kind_e;

  typedef enum logic {
    WS_IDLE,
    WS_STALL
  } wr_state_e;

  typedef struct packed {
    dec_kind_e        kind;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // RW window starts at 0, RO window at ro_base; anything else is unmapped.
  function automatic dec_t decode_addr(
    input logic [AVM_AW-1:0] addr,
    input int                n_rw,
    input int                n_ro,
    input logic [AVM_AW-1:0] ro_base
  );
    dec_t d;
    int   a;
    int   b;
    a      = int'(addr);
    b      = int'(ro_base);
    d.kind = DEC_NONE;
    d.idx  = '0;
    if (a < n_rw) begin
      d.kind = DEC_RW;
      d.idx  = IDX_W'(a);
    end else if ((a >= b) && (a < b + n_ro)) begin
      d.kind = DEC_RO;
      d.idx  = IDX_W'(a - b);
    end
    return d;
  endfunction

endpackage

// File: rtl/avmm_rd_pipe.sv
// Fixed-latency read-response pipeline: LAT stages of valid bit plus data.
// Data is zeroed on empty slots so readdata never shows stale decode results.
module avmm_rd_pipe
  import avmm_reg_pkg::*;
#(
  parameter int LAT = 2,
  parameter int DW  = AVM_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [LAT-1:0] vld;
  logic [DW-1:0]  dat [LAT];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++) begin
        dat[k] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int k = 1; k < LAT; k++) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/avmm_reg_slave.sv
// Avalon-MM 8-bit register bank: RW control registers, RO status window,
// programmable write wait states, fixed-latency pipelined reads and an error counter.
module avmm_reg_slave
  import avmm_reg_pkg::*;
#(
  parameter int                N_RW    = 16,
  parameter int                N_RO    = 8,
  parameter logic [AVM_AW-1:0] RO_BASE = 8'h80,
  parameter int                RD_LAT  = 2,
  parameter int                WR_WAIT = 1,
  parameter logic [AVM_DW-1:0] RW_RST  = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [AVM_AW-1:0]      avs_address,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [AVM_DW-1:0]      avs_writedata,
  output logic                   avs_waitrequest,
  output logic [AVM_DW-1:0]      avs_readdata,
  output logic                   avs_readdatavalid,
  output logic [8*N_RW-1:0]      rw_regs,
  output logic [N_RW-1:0]        wr_strobe,
  input  logic [8*N_RO-1:0]      ro_in,
  output logic [AVM_DW-1:0]      err_cnt
);

  if (N_RW < 1 || N_RW > 64 || N_RO < 1 || N_RO > 64 ||
      RD_LAT < 1 || RD_LAT > 4 || WR_WAIT < 0 || WR_WAIT > 3) begin : g_bad_range
    $error("avmm_reg_slave: parameter out of range");
  end
  if (int'(RO_BASE) < N_RW || int'(RO_BASE) + N_RO > 256) begin : g_bad_map
    $error("avmm_reg_slave: RW and RO windows overlap or RO window exceeds address space");
  end

  localparam logic [1:0] WAIT_LAST = 2'(WR_WAIT);

  logic        rst_q;
  logic [1:0]  wcnt;
  wr_state_e   wr_state;
  dec_t        dec;
  logic        wr_only;
  logic        wr_stall;
  logic        rd_acc;
  logic        wr_acc;
  logic        wr_rw;
  logic        both_acc;
  logic        err_inc;
  logic [7:0]  rd_snap;
  logic [7:0]  rw_q [N_RW];

  // Handshake: a command (read or write) is taken on a rising clk edge where it is
  // asserted and avs_waitrequest is low; the master holds address/data while stalled.
  // Each taken read yields exactly one avs_readdatavalid, RD_LAT cycles later, in order.
  // A read+write in the same cycle is serviced as a read only and counted as an error.
  always_comb begin
    dec             = decode_addr(avs_address, N_RW, N_RO, RO_BASE);
    wr_only         = avs_write && !avs_read;
    wr_stall        = wr_only && (wcnt != WAIT_LAST);
    avs_waitrequest = !reset_n || rst_q || wr_stall;
    rd_acc          = avs_read && !avs_waitrequest;
    wr_acc          = wr_only && !avs_waitrequest;
    wr_rw           = wr_acc && (dec.kind == DEC_RW);
    both_acc        = avs_read && avs_write && !avs_waitrequest;
    err_inc         = (rd_acc && (dec.kind == DEC_NONE)) ||
                      (wr_acc && (dec.kind != DEC_RW)) ||
                      both_acc;
  end

  // Write wait-state FSM; wcnt counts stall cycles and clears on accept or abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_q    <= 1'b1;
      wcnt     <= '0;
      wr_state <= WS_IDLE;
    end else begin
      rst_q <= 1'b0;
      case (wr_state)
        WS_IDLE: begin
          if (wr_stall && !rst_q) begin
            wcnt     <= 2'd1;
            wr_state <= WS_STALL;
          end else begin
            wcnt <= '0;
          end
        end
        WS_STALL: begin
          if (wr_stall) begin
            wcnt <= wcnt + 2'd1;
          end else begin
            wcnt     <= '0;
            wr_state <= WS_IDLE;
          end
        end
        default: begin
          wcnt     <= '0;
          wr_state <= WS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_strobe <= '0;
      for (int k = 0; k < N_RW; k++) begin
        rw_q[k] <= RW_RST;
      end
    end else begin
      for (int k = 0; k < N_RW; k++) begin
        wr_strobe[k] <= wr_rw && (int'(dec.idx) == k);
        if (wr_rw && (int'(dec.idx) == k)) begin
          rw_q[k] <= avs_writedata;
        end
      end
    end
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_flat
    assign rw_regs[8*g +: 8] = rw_q[g];
  end

  // Snapshot at acceptance: RO inputs are sampled in the accept cycle, not at readdatavalid.
  always_comb begin
    rd_snap = '0;
    for (int k = 0; k < N_RW; k++) begin
      if ((dec.kind == DEC_RW) && (int'(dec.idx) == k)) begin
        rd_snap = rw_q[k];
      end
    end
    for (int k = 0; k < N_RO; k++) begin
      if ((dec.kind == DEC_RO) && (int'(dec.idx) == k)) begin
        rd_snap = ro_in[8*k +: 8];
      end
    end
  end

  avmm_rd_pipe #(
    .LAT (RD_LAT),
    .DW  (AVM_DW)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_acc),
    .in_data   (rd_snap),
    .out_valid (avs_readdatavalid),
    .out_data  (avs_readdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (err_inc && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_avmm_reg_slave.sv
// Directed bench for avmm_reg_slave: read responses go through an expected-data queue
// checked by an independent monitor; register, strobe and error state checked inline.
module tb_avmm_reg_slave;

  localparam int N_RW   = 16;
  localparam int N_RO   = 8;
  localparam int RD_LAT = 2;

  logic                clk;
  logic                reset_n;
  logic [7:0]          avs_address;
  logic                avs_read;
  logic                avs_write;
  logic [7:0]          avs_writedata;
  logic                avs_waitrequest;
  logic [7:0]          avs_readdata;
  logic                avs_readdatavalid;
  logic [8*N_RW-1:0]   rw_regs;
  logic [N_RW-1:0]     wr_strobe;
  logic [8*N_RO-1:0]   ro_in;
  logic [7:0]          err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  avmm_reg_slave #(
    .N_RW    (N_RW),
    .N_RO    (N_RO),
    .RO_BASE (8'h80),
    .RD_LAT  (RD_LAT),
    .WR_WAIT (1),
    .RW_RST  (8'h00)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .rw_regs           (rw_regs),
    .wr_strobe         (wr_strobe),
    .ro_in             (ro_in),
    .err_cnt           (err_cnt)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp);
    int g = 0;
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    while (avs_waitrequest && g < 20) begin
      g++;
      @(negedge clk);
    end
    check("rd_waits", g, 0);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + RD_LAT);
    step();
    avs_read = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int exp_waits);
    int g = 0;
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    while (avs_waitrequest && g < 20) begin
      g++;
      @(negedge clk);
    end
    check("wr_waits", g, exp_waits);
    step();
    avs_write = 1'b0;
  endtask

  task automatic do_illegal(input logic [7:0] addr, input logic [7:0] data, input logic [7:0] exp);
    int g = 0;
    avs_address   = addr;
    avs_writedata = data;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk);
    while (avs_waitrequest && g < 20) begin
      g++;
      @(negedge clk);
    end
    check("illegal_waits", g, 0);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + RD_LAT);
    step();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: readdatavalid with data 'h%0h at cycle %0d, none expected",
                 avs_readdata, cyc);
      end else begin
        logic [7:0] e;
        int         c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        checks++;
        if (avs_readdata !== e) begin
          errors++;
          $display("FAIL rd_data: got 'h%0h, expected 'h%0h (cycle %0d)", avs_readdata, e, cyc);
        end
        checks++;
        if (cyc != c) begin
          errors++;
          $display("FAIL rd_latency: valid at cycle %0d, expected cycle %0d", cyc, c);
        end
      end
    end
  end

  initial begin
    int g;
    reset_n       = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    ro_in         = 64'h8877_6655_4433_3C5A;

    repeat (3) step();
    @(negedge clk);
    check("rst_waitreq", 32'(avs_waitrequest), 1);
    check("rst_rdvalid", 32'(avs_readdatavalid), 0);
    check("rst_readdata", 32'(avs_readdata), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_rw_regs", 32'(|rw_regs), 0);
    check("rst_strobe", 32'(wr_strobe), 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("waitreq_after_release", 32'(avs_waitrequest), 1);
    step();
    @(negedge clk);
    check("waitreq_idle", 32'(avs_waitrequest), 0);
    step();

    // write 0xA5 to 0x03: one wait cycle, strobe one cycle after accept
    do_write(8'h03, 8'hA5, 1);
    @(negedge clk);
    check("strobe_3", 32'(wr_strobe), 'h0008);
    check("rw3_a5", 32'(rw_regs[31:24]), 'hA5);
    step();
    @(negedge clk);
    check("strobe_3_off", 32'(wr_strobe), 0);
    step();

    // back-to-back reads
    do_read(8'h81, 8'h3C);
    do_read(8'h03, 8'hA5);
    do_read(8'h81, 8'h3C);

    // read-after-write
    do_write(8'h00, 8'h11, 1);
    do_read(8'h00, 8'h11);

    // write dropped before acceptance
    avs_address   = 8'h02;
    avs_writedata = 8'hEE;
    avs_write     = 1'b1;
    @(negedge clk);
    check("abort_waitreq", 32'(avs_waitrequest), 1);
    step();
    avs_write = 1'b0;
    @(negedge clk);
    check("abort_rw2", 32'(rw_regs[23:16]), 0);
    check("abort_strobe", 32'(wr_strobe), 0);
    step();

    // error counting: RO write, unmapped read, read+write together
    do_write(8'h80, 8'h99, 1);
    @(negedge clk);
    check("ro_write_strobe", 32'(wr_strobe), 0);
    step();
    do_read(8'h40, 8'h00);
    do_illegal(8'h05, 8'h77, 8'h00);
    @(negedge clk);
    check("err_three", 32'(err_cnt), 3);
    check("illegal_rw5", 32'(rw_regs[47:40]), 0);
    step();
    do_read(8'h80, 8'h5A);

    // window boundaries and RO sampling at acceptance
    ro_in[15:8] = 8'hC3;
    do_write(8'h0F, 8'h5C, 1);
    @(negedge clk);
    check("strobe_15", 32'(wr_strobe), 'h8000);
    step();
    do_read(8'h81, 8'hC3);
    do_read(8'h87, 8'h88);
    do_read(8'h0F, 8'h5C);
    do_read(8'h88, 8'h00);
    do_read(8'h10, 8'h00);
    do_read(8'hFF, 8'h00);
    @(negedge clk);
    check("err_six", 32'(err_cnt), 6);
    step();

    // saturation
    for (int i = 0; i < 300; i++) begin
      do_read(8'h40, 8'h00);
    end
    @(negedge clk);
    check("err_saturated", 32'(err_cnt), 'hFF);
    step();

    g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      g++;
      @(negedge clk);
    end
    check("drain_before_reset", exp_q.size(), 0);
    step();

    // reset one cycle after a read is accepted
    avs_address = 8'h03;
    avs_read    = 1'b1;
    @(negedge clk);
    check("pre_reset_waitreq", 32'(avs_waitrequest), 0);
    step();
    avs_read = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    check("mid_reset_waitreq", 32'(avs_waitrequest), 1);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_waitreq", 32'(avs_waitrequest), 1);
    check("post_reset_rdvalid", 32'(avs_readdatavalid), 0);
    check("post_reset_rw_regs", 32'(|rw_regs), 0);
    check("post_reset_err", 32'(err_cnt), 0);
    step();
    @(negedge clk);
    check("post_reset_idle", 32'(avs_waitrequest), 0);
    check("post_reset_rdvalid2", 32'(avs_readdatavalid), 0);
    repeat (4) step();

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
